// File: rtl/key_conditioner.sv
// key_conditioner: synchronise, debounce and time four raw game keys.
// Each key gets a 2-flop synchroniser, a consecutive-cycle debounce filter,
// one-cycle press/release pulses and a saturating hold-duration counter
// driven by a shared free-running prescaler.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned HOLD_DIV        = 100000,
  parameter bit          ACTIVE_LOW_IN   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_in,
  output logic [3:0]  key_level,
  output logic [3:0]  key_press,
  output logic [3:0]  key_release,
  output logic [63:0] hold_cnt
);

  localparam int unsigned N_KEYS = 4;
  localparam int unsigned HOLD_W = 16;
  localparam int unsigned PRE_W  = (HOLD_DIV > 1) ? $clog2(HOLD_DIV) : 1;

  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(HOLD_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

  logic [N_KEYS-1:0] raw_c;

  logic [N_KEYS-1:0] s1_q, s1_d;
  logic [N_KEYS-1:0] s2_q, s2_d;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];
  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              tick_c;
  logic [HOLD_W-1:0] hold_q [N_KEYS];
  logic [HOLD_W-1:0] hold_d [N_KEYS];

  // Normalise polarity so 1 always means pressed.
  assign raw_c = key_in ^ {N_KEYS{ACTIVE_LOW_IN}};

  // Two-stage synchroniser for the asynchronous key inputs.
  always_comb begin
    s1_d = raw_c;
    s2_d = s1_q;
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          level_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edge pulses are registered alongside the level change they describe.
  always_comb begin
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  // Shared free-running prescaler; tick marks its last count.
  always_comb begin
    tick_c = (pre_q == PRE_LAST);
    pre_d  = tick_c ? '0 : pre_q + PRE_W'(1);
  end

  // Hold counters: cleared unless the key stays pressed, saturating tick count otherwise.
  always_comb begin
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      hold_d[i] = '0;
      if (level_q[i] && level_d[i]) begin
        hold_d[i] = hold_q[i];
        if (tick_c && (hold_q[i] != HOLD_MAX)) begin
          hold_d[i] = hold_q[i] + HOLD_W'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      pre_q     <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      pre_q     <= pre_d;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

  // Pack per-key hold counts, key i in bits [16*i+15:16*i].
  for (genvar g = 0; g < N_KEYS; g++) begin : g_pack
    assign hold_cnt[HOLD_W*g +: HOLD_W] = hold_q[g];
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_key_conditioner;

  localparam int unsigned DEB = 4;
  localparam int unsigned HD1 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  key_in = 4'h0;
  logic [3:0]  key_level, key_press, key_release;
  logic [63:0] hold_cnt;

  logic [3:0]  key_in2 = 4'h0;
  logic [3:0]  key_level2, key_press2, key_release2;
  logic [63:0] hold_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  key_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3), .HOLD_DIV(HD1), .ACTIVE_LOW_IN(1'b0)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .hold_cnt(hold_cnt)
  );

  key_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3), .HOLD_DIV(1), .ACTIVE_LOW_IN(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .key_in(key_in2), .key_level(key_level2),
    .key_press(key_press2), .key_release(key_release2), .hold_cnt(hold_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a key's level flips once the synchronised input has
  // disagreed with it for DEB consecutive cycles; hold counts prescaler ticks
  // while the key stays down.
  logic [3:0]  m_h1 = '0, m_h2 = '0, m_lvl = '0, m_prs = '0, m_rel = '0;
  logic [3:0]  m_nl;
  int unsigned m_run [4] = '{0, 0, 0, 0};
  int unsigned m_hold [4] = '{0, 0, 0, 0};
  int unsigned m_k = 0;
  bit          m_tick;
  logic [63:0] m_hold_pk;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_h1 = '0; m_h2 = '0; m_lvl = '0; m_prs = '0; m_rel = '0; m_k = 0;
      for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_hold[i] = 0; end
    end else begin
      m_k++;
      m_tick = ((m_k % HD1) == 0);
      m_nl = m_lvl;
      for (int i = 0; i < 4; i++) begin
        if (m_h2[i] == m_lvl[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DEB) begin m_nl[i] = m_h2[i]; m_run[i] = 0; end
        end
        if (m_lvl[i] && m_nl[i]) begin
          if (m_tick && m_hold[i] < 65535) m_hold[i]++;
        end else m_hold[i] = 0;
      end
      m_prs = m_nl & ~m_lvl;
      m_rel = ~m_nl & m_lvl;
      m_lvl = m_nl;
      m_h2  = m_h1;
      m_h1  = key_in;
    end
  end

  // Model comparison on every falling edge.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 4; i++) m_hold_pk[16*i +: 16] = 16'(m_hold[i]);
    chk("m_level",   64'(key_level),   64'(m_lvl));
    chk("m_press",   64'(key_press),   64'(m_prs));
    chk("m_release", 64'(key_release), 64'(m_rel));
    chk("m_hold",    hold_cnt,         m_hold_pk);
  end

  typedef struct {
    logic [3:0] kin;
    int         edges;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
  } vec_t;

  vec_t vecs [12];
  int   rem [4];
  logic [15:0] h, prev;
  int   last_inc;
  bit   seen;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'h1, 5, 4'h0, 4'h0, 4'h0};
    vecs[1]  = '{4'h1, 1, 4'h1, 4'h1, 4'h0};
    vecs[2]  = '{4'h1, 1, 4'h1, 4'h0, 4'h0};
    vecs[3]  = '{4'h0, 5, 4'h1, 4'h0, 4'h0};
    vecs[4]  = '{4'h0, 1, 4'h0, 4'h0, 4'h1};
    vecs[5]  = '{4'h0, 1, 4'h0, 4'h0, 4'h0};
    vecs[6]  = '{4'hF, 5, 4'h0, 4'h0, 4'h0};
    vecs[7]  = '{4'hF, 1, 4'hF, 4'hF, 4'h0};
    vecs[8]  = '{4'hF, 1, 4'hF, 4'h0, 4'h0};
    vecs[9]  = '{4'h0, 5, 4'hF, 4'h0, 4'h0};
    vecs[10] = '{4'h0, 1, 4'h0, 4'h0, 4'hF};
    vecs[11] = '{4'h0, 1, 4'h0, 4'h0, 4'h0};

    repeat (3) @(negedge clk);
    chk("reset_level", 64'(key_level), 64'h0);
    chk("reset_press", 64'(key_press), 64'h0);
    chk("reset_hold",  hold_cnt,       64'h0);
    rst = 1'b1;

    // Directed vectors: latency, single-cycle pulses, simultaneous keys.
    foreach (vecs[v]) begin
      key_in = vecs[v].kin;
      repeat (vecs[v].edges) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_level", v),   64'(key_level),   64'(vecs[v].lvl));
      chk($sformatf("vec%0d_press", v),   64'(key_press),   64'(vecs[v].prs));
      chk($sformatf("vec%0d_release", v), 64'(key_release), 64'(vecs[v].rel));
    end

    // Glitch of 3 cycles on key 1 never reaches the level.
    key_in = 4'h2;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) key_in = 4'h0;
      @(posedge clk); @(negedge clk);
      chk("glitch_level", 64'(key_level[1]), 64'h0);
      chk("glitch_press", 64'(key_press[1]), 64'h0);
      chk("glitch_hold",  64'(hold_cnt[31:16]), 64'h0);
    end

    // Key 2 held 60 cycles: hold steps by one exactly every 3 cycles.
    key_in = 4'h4;
    prev = 16'h0; last_inc = -1; h = 16'h0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); @(negedge clk);
      h = hold_cnt[47:32];
      if (h != prev) begin
        chk("t3_step", 64'(h), 64'(prev + 16'h1));
        if (last_inc >= 0) chk("t3_period", 64'(c - last_inc), 64'd3);
        last_inc = c;
        prev = h;
      end
    end
    chk("t3_total", 64'(h), 64'd18);
    key_in = 4'h0;
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(posedge clk); @(negedge clk);
      if (key_release[2]) begin
        seen = 1'b1;
        chk("t3_rel_hold",  64'(hold_cnt[47:32]), 64'h0);
        chk("t3_rel_level", 64'(key_level[2]),    64'h0);
      end
    end
    chk("t3_release_seen", 64'(seen), 64'h1);

    // Saturation with HOLD_DIV=1 on key 3.
    key_in2 = 4'h8;
    repeat (6 + 1000) @(posedge clk);
    @(negedge clk);
    chk("sat_mid",   64'(hold_cnt2[63:48]), 64'd1000);
    repeat (65000) @(posedge clk);
    @(negedge clk);
    chk("sat_top",   64'(hold_cnt2[63:48]), 64'hFFFF);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("sat_stay",  64'(hold_cnt2[63:48]), 64'hFFFF);
    chk("sat_level", 64'(key_level2), 64'h8);
    key_in2 = 4'h0;

    // Randomized run checked by the model.
    for (int i = 0; i < 4; i++) rem[i] = 0;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0) begin
          key_in[i] = 1'($urandom_range(0, 1));
          rem[i] = int'($urandom_range(1, 9));
        end
        rem[i]--;
      end
      @(negedge clk);
    end

    // Async reset with keys held, then a fresh press after release.
    key_in = 4'h0;
    repeat (10) @(negedge clk);
    key_in = 4'hF;
    repeat (18) @(negedge clk);
    chk("t6_pre_hold_nz", 64'(hold_cnt[15:0] != 16'h0), 64'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_level", 64'(key_level),   64'h0);
    chk("t6_async_press", 64'(key_press),   64'h0);
    chk("t6_async_rel",   64'(key_release), 64'h0);
    chk("t6_async_hold",  hold_cnt,         64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t6_early_press", 64'(key_press), 64'h0);
    @(posedge clk); @(negedge clk);
    chk("t6_press", 64'(key_press), 64'hF);
    chk("t6_level", 64'(key_level), 64'hF);
    @(posedge clk); @(negedge clk);
    chk("t6_press_end", 64'(key_press), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
